// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between a configuration source and ccff_chain_loader.
// A word transfers on every prog_clk rising edge where cfg_valid && cfg_ready; cfg_valid must not wait on cfg_ready.
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises a word stream MSB-first into a configuration flip-flop chain.
// Define CCFF_READBACK_EN to add a CRC-16 recirculating readback check after loading.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8
) (
   input  logic                 prog_clk,
   input  logic                 pReset,
   input  logic                 start,
   ccff_chain_loader_if.slave   cfg,
   output logic                 ccff_head,
   output logic                 ccff_shift,
   input  logic                 ccff_tail,
   output logic                 config_enable,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           fsm_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam int BW = $clog2(WORD_W + 1);

   state_t            state_q;
   logic [CW-1:0]     bit_cnt_q;
   logic [WORD_W-1:0] buf_q;
   logic [BW-1:0]     buf_cnt_q;
   logic              err_q;
   logic              busy_q;
   logic              cen_q;
   logic              done_q;

   logic buf_has;
   logic last_bit;
   logic load_shift;
   logic ready_int;
   logic take;

   assign buf_has    = (buf_cnt_q != '0);
   assign last_bit   = (bit_cnt_q == CW'(CHAIN_LEN - 1));
   assign load_shift = (state_q == LOAD) && buf_has;
   // Ready also when the last buffered bit leaves this cycle, so words stream without a bubble.
   assign ready_int  = (state_q == LOAD) && (!buf_has || buf_cnt_q == BW'(1));
   assign take       = ready_int && cfg.cfg_valid;

`ifdef CCFF_READBACK_EN
   logic [15:0] crc_load_q;
   logic [15:0] crc_tail_q;
   logic        verify_on;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   assign verify_on = (state_q == VERIFY);
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
`endif

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         buf_q     <= '0;
         buf_cnt_q <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         cen_q     <= 1'b0;
         done_q    <= 1'b0;
`ifdef CCFF_READBACK_EN
         crc_load_q <= 16'hFFFF;
         crc_tail_q <= 16'hFFFF;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= LOAD;
                  bit_cnt_q <= '0;
                  buf_cnt_q <= '0;
                  err_q     <= 1'b0;
                  busy_q    <= 1'b1;
                  cen_q     <= 1'b1;
`ifdef CCFF_READBACK_EN
                  crc_load_q <= 16'hFFFF;
                  crc_tail_q <= 16'hFFFF;
`endif
               end
            end
            LOAD: begin
               if (buf_has) begin
                  buf_q     <= buf_q << 1;
                  buf_cnt_q <= buf_cnt_q - BW'(1);
                  bit_cnt_q <= bit_cnt_q + CW'(1);
`ifdef CCFF_READBACK_EN
                  crc_load_q <= crc_step(crc_load_q, buf_q[WORD_W-1]);
`endif
                  if (last_bit) begin
                     // Leftover bits of the final word are dropped here.
                     buf_cnt_q <= '0;
                     bit_cnt_q <= '0;
`ifdef CCFF_READBACK_EN
                     state_q <= VERIFY;
`else
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     cen_q   <= 1'b0;
`endif
                  end
               end
               if (take && !(buf_has && last_bit)) begin
                  buf_q     <= cfg.cfg_data;
                  buf_cnt_q <= BW'(WORD_W);
               end
            end
`ifdef CCFF_READBACK_EN
            VERIFY: begin
               crc_tail_q <= crc_step(crc_tail_q, ccff_tail);
               bit_cnt_q  <= bit_cnt_q + CW'(1);
               if (last_bit) begin
                  err_q     <= (crc_load_q != crc_step(crc_tail_q, ccff_tail));
                  bit_cnt_q <= '0;
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  cen_q     <= 1'b0;
               end
            end
`endif
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs are forced quiet for the whole time reset is held, not just after the edge.
   assign cfg.cfg_ready   = !pReset && ready_int;
   assign config_enable   = !pReset && cen_q;
   assign busy            = !pReset && busy_q;
   assign done            = !pReset && done_q;
   assign err             = !pReset && err_q;
   assign fsm_state       = state_q;
`ifdef CCFF_READBACK_EN
   assign ccff_shift = !pReset && (load_shift || verify_on);
   assign ccff_head  = !pReset && (load_shift ? buf_q[WORD_W-1] : (verify_on && ccff_tail));
`else
   assign ccff_shift = !pReset && load_shift;
   assign ccff_head  = !pReset && load_shift && buf_q[WORD_W-1];
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with CHAIN_LEN=20, WORD_W=8 and a delay-line chain model.
module tb_ccff_chain_loader;
  localparam int CL = 20;
  localparam int WW = 8;
`ifdef CCFF_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          gap;
    bit          mid_start;
    bit          force7;
    logic [19:0] exp_bits;
    int          exp_busy;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, tail, head, shift, cen, busy, done, err;
  logic [1:0] st;
  ccff_chain_loader_if #(.WORD_W(WW)) cfg_if ();

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(clk), .pReset(rst), .start(start), .cfg(cfg_if.slave),
    .ccff_head(head), .ccff_shift(shift), .ccff_tail(tail),
    .config_enable(cen), .busy(busy), .done(done), .err(err), .fsm_state(st)
  );

  // Delay-line chain: first bit in ends up at the tail after CL shifts.
  logic [CL-1:0] chain;
  logic [CL-1:0] chain_nxt;
  logic          force7;
  assign tail = chain[CL-1];
  always @(posedge clk) begin
    if (shift) begin
      chain_nxt = {chain[CL-2:0], head};
      if (force7) chain_nxt[7] = 1'b1;
      chain <= chain_nxt;
    end
  end

  int   checks = 0;
  int   failures = 0;
  logic prev_err = 1'b0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_load(input vec_t v, input int idx);
    logic [7:0]  words[3];
    logic [19:0] bits;
    logic        err_d, err_pre, err_first;
    int wi, gap_left, nshift, ndone, nbusy, last_k, done_k, idle_after;
    string p;
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
    bits = 'x; err_d = 1'bx; err_pre = 1'bx; err_first = 1'bx;
    wi = 0; gap_left = 0; nshift = 0; ndone = 0; nbusy = 0;
    last_k = -1; done_k = -100; idle_after = 0;
    force7 = v.force7;
    p = $sformatf("v%0d", idx);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) err_pre = err;
      if (k == 1) err_first = err;
      if (shift) begin
        if (nshift < CL) bits[CL-1-nshift] = head;
        nshift++;
        last_k = k;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        done_k = k;
        err_d = err;
      end
      if (ndone > 0 && !busy) idle_after++;
      start = (k == 0) || (v.mid_start && k == 6);
      if (wi < 3 && gap_left == 0) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = words[wi];
      end else begin
        cfg_if.cfg_valid = 1'b0;
      end
      if (cfg_if.cfg_ready) begin
        if (cfg_if.cfg_valid) begin
          wi++;
          if (wi == 1) gap_left = v.gap;
        end else if (gap_left > 0 && wi < 3) begin
          gap_left--;
        end
      end
      if (idle_after >= 3) break;
    end
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    force7 = 1'b0;
    check({p, "_err_sticky"}, err_pre, prev_err);
    check({p, "_err_clear"}, err_first, 1'b0);
    check({p, "_bits"}, bits, v.exp_bits);
    check({p, "_nshift"}, nshift, CL * (1 + RB));
    check({p, "_ndone"}, ndone, 1);
    check({p, "_done_delay"}, done_k - last_k, 1);
    check({p, "_busy_cycles"}, nbusy, v.exp_busy);
    check({p, "_err_at_done"}, err_d, v.exp_err);
    if (!v.force7) check({p, "_chain"}, chain, v.exp_bits);
    prev_err = v.exp_err;
  endtask

  task automatic check_quiet(input string p);
    check({p, "_ready"}, cfg_if.cfg_ready, 1'b0);
    check({p, "_head"}, head, 1'b0);
    check({p, "_shift"}, shift, 1'b0);
    check({p, "_cen"}, cen, 1'b0);
    check({p, "_busy"}, busy, 1'b0);
    check({p, "_done"}, done, 1'b0);
    check({p, "_err"}, err, 1'b0);
    check({p, "_state"}, st, 2'd0);
  endtask

  initial begin
    int nshift, ndone, wi;
    logic [7:0] words[3];
    vecs[0] = '{8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0, 20'hA53CF, 22 + 20 * RB, 1'b0};
    vecs[1] = '{8'hA5, 8'h3C, 8'hF0, 3, 1'b0, 1'b0, 20'hA53CF, 25 + 20 * RB, 1'b0};
    vecs[2] = '{8'hA5, 8'h3C, 8'hF0, 0, 1'b1, 1'b0, 20'hA53CF, 22 + 20 * RB, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 8'h81, 1, 1'b0, 1'b0, 20'hFF008, 23 + 20 * RB, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 20'h00000, 22 + 20 * RB, 1'(RB)};
    vecs[5] = '{8'h12, 8'h34, 8'h56, 0, 1'b0, 1'b0, 20'h12345, 22 + 20 * RB, 1'b0};

    rst = 1'b1; start = 1'b0; force7 = 1'b0; chain = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    for (int i = 0; i < 6; i++) run_load(vecs[i], i);

    // Abort a load with reset after ten bits have gone into the chain.
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
    nshift = 0; ndone = 0; wi = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (shift) nshift++;
      if (done) ndone++;
      start = (k == 0);
      cfg_if.cfg_valid = (wi < 3);
      if (wi < 3) cfg_if.cfg_data = words[wi];
      if (cfg_if.cfg_ready && cfg_if.cfg_valid) wi++;
      if (nshift == 10) begin
        rst = 1'b1;
        break;
      end
    end
    check("abort_reached_10", nshift, 10);
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    prev_err = 1'b0;
    run_load(vecs[0], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
